// File: rtl/lcd_sink.sv
// lcd_sink: HD44780-style 2x16 LCD bus responder with 32-byte display RAM, busy timing and debug read port
module lcd_sink #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1640
) (
  input  logic       lcdclk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       busy,
  output logic       write_strobe,
  output logic       protocol_err
);
  localparam logic [10:0] BUSY_N  = 11'(BUSY_CYCLES);
  localparam logic [10:0] CLEAR_N = 11'(CLEAR_CYCLES);
  logic en_d1_q, en_d2_q, rs_q, rw_q, oe_q, id_q, disp_q, ws_q, perr_q;
  logic [7:0] data_q, dbg_q;
  logic [6:0] cur_q, cur_inc, cur_dec;
  logic [10:0] cnt_q;
  logic [31:0][7:0] ram_q;
  logic rise, fall, commit, busy_w;
  logic [4:0] idx;
  assign rise    = en_d1_q & ~en_d2_q;
  assign fall    = en_d2_q & ~en_d1_q;
  assign busy_w  = cnt_q != 11'd0;
  assign commit  = fall & ~(~rs_q & rw_q);
  assign idx     = {cur_q[6], cur_q[3:0]};
  assign cur_inc = cur_q == 7'h0F ? 7'h40 : cur_q == 7'h4F ? 7'h00 : cur_q + 7'd1;
  assign cur_dec = cur_q == 7'h00 ? 7'h4F : cur_q == 7'h40 ? 7'h0F : cur_q - 7'd1;
  assign lcd_data_out = oe_q ? (rs_q ? ram_q[idx] : {busy_w, cur_q}) : 8'h00;
  assign lcd_data_oe  = oe_q;
  assign dbg_char     = dbg_q;
  assign cursor_addr  = cur_q;
  assign disp_on      = disp_q;
  assign busy         = busy_w;
  assign write_strobe = ws_q;
  assign protocol_err = perr_q;
  always_ff @(posedge lcdclk) begin
    if (reset) begin
      en_d1_q <= 1'b0;
      en_d2_q <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= 8'h00;
      oe_q    <= 1'b0;
      cur_q   <= 7'h00;
      id_q    <= 1'b1;
      disp_q  <= 1'b0;
      cnt_q   <= 11'd0;
      ws_q    <= 1'b0;
      perr_q  <= 1'b0;
      dbg_q   <= 8'h20;
      ram_q   <= {32{8'h20}};
    end else begin
      en_d1_q <= lcd_en;
      en_d2_q <= en_d1_q;
      if (en_d1_q) begin
        rs_q   <= lcd_rs;
        rw_q   <= lcd_rw;
        data_q <= lcd_data_in;
      end
      dbg_q  <= ram_q[dbg_addr];
      ws_q   <= 1'b0;
      perr_q <= 1'b0;
      if (rise && lcd_rw) oe_q <= 1'b1;
      else if (fall) oe_q <= 1'b0;
      if (busy_w) cnt_q <= cnt_q - 11'd1;
      if (commit && busy_w) perr_q <= 1'b1;
      else if (commit) begin
        cnt_q <= BUSY_N;
        if (rs_q) begin
          cur_q <= id_q ? cur_inc : cur_dec;
          if (!rw_q) begin
            ram_q[idx] <= data_q;
            ws_q       <= 1'b1;
          end
        end else if (data_q[7]) cur_q <= {data_q[6], 2'b00, data_q[3:0]};
        else if (data_q[6:5] == 2'b00) begin
          if (data_q[4]) begin
            if (!data_q[3]) cur_q <= data_q[2] ? cur_inc : cur_dec;
          end else if (data_q[3]) disp_q <= data_q[2];
          else if (data_q[2]) id_q <= data_q[1];
          else if (data_q[1]) begin
            cur_q <= 7'h00;
            cnt_q <= CLEAR_N;
          end else if (data_q[0]) begin
            cur_q <= 7'h00;
            id_q  <= 1'b1;
            cnt_q <= CLEAR_N;
            ram_q <= {32{8'h20}};
          end
        end
      end
    end
  end
endmodule
